// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared op/state encodings, iteration count and operand helper
package mdu_ctrl_pkg;
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_e;
  localparam int MDU_ITER = 32;
  // magnitude of v when treated as signed, raw v otherwise
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-stage request and HI/LO writeback bundle for the multiply/divide unit
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;
  logic        start;
  mdu_op_e     op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        stallreq;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        div_by_zero;
  modport master (
    output start, op, src_a, src_b, cancel,
    input  stallreq, busy, hilo_we, hi_wdata, lo_wdata, div_by_zero
  );
  modport slave (
    input  start, op, src_a, src_b, cancel,
    output stallreq, busy, hilo_we, hi_wdata, lo_wdata, div_by_zero
  );
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational shift-add (multiply) or restoring-subtract (divide) iteration
module mdu_step (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);
  logic [32:0] sum;
  logic [31:0] diff;
  logic        ge;
  // multiply: acc = {partial_hi, multiplier}; add multiplicand on lsb, then shift right
  assign sum = {1'b0, acc[63:32]} + {1'b0, acc[0] ? opnd : 32'd0};
  // divide: acc = {remainder, quotient}; shifted remainder is acc[63:31], may need 33 bits
  assign ge = acc[63:31] >= {1'b0, opnd};
  assign diff = acc[62:31] - opnd;
  assign acc_next = is_div ? (ge ? {diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0})
                           : {sum, acc[31:1]};
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative 32-cycle multiply/divide unit with pipeline stall and flush control
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input logic       clk,
  input logic       resetn,
  mdu_ctrl_if.slave bus
);
  mdu_state_e  state, state_nx;
  mdu_op_e     op_q;
  logic        sign_a, sign_b, dbz;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_step, res, prod;
  logic [31:0] opnd, quo, rem;
  logic        accept, by_zero, is_signed, is_div, neg_q;
  assign accept    = state == IDLE && bus.start && !bus.cancel;
  assign by_zero   = bus.op[1] && bus.src_b == 32'd0;
  assign is_signed = !op_q[0];
  assign is_div    = op_q[1];
  mdu_step u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  // next state: cancel wins over everything, start only honoured in IDLE
  always_comb begin
    state_nx = state;
    state_nx = bus.cancel      ? IDLE :
               state == IDLE   ? (bus.start ? (by_zero ? DONE : RUN) : IDLE) :
               state == RUN    ? (cnt == 5'(MDU_ITER - 1) ? DONE : RUN) :
                                 IDLE;
  end
  // operand capture on accept, one datapath iteration per RUN cycle
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      op_q   <= MDU_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dbz    <= 1'b0;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
    end else if (accept) begin
      op_q   <= bus.op;
      sign_a <= bus.src_a[31];
      sign_b <= bus.src_b[31];
      dbz    <= by_zero;
      cnt    <= 5'd0;
      acc    <= by_zero ? {bus.src_a, 32'hFFFF_FFFF}
                        : {32'd0, bus.op[1] ? abs32(bus.src_a, !bus.op[0]) : abs32(bus.src_b, !bus.op[0])};
      opnd   <= bus.op[1] ? abs32(bus.src_b, !bus.op[0]) : abs32(bus.src_a, !bus.op[0]);
    end else if (state == RUN) begin
      acc <= acc_step;
      cnt <= cnt + 5'd1;
    end
  // sign fix-up of the unsigned magnitude result; divide-by-zero bypasses it
  assign neg_q = is_signed && (sign_a ^ sign_b);
  assign prod  = neg_q ? -acc : acc;
  assign quo   = neg_q ? -acc[31:0] : acc[31:0];
  assign rem   = (is_signed && sign_a) ? -acc[63:32] : acc[63:32];
  assign res   = dbz ? acc : is_div ? {rem, quo} : prod;
  assign bus.hilo_we     = state == DONE && !bus.cancel;
  assign bus.hi_wdata    = bus.hilo_we ? res[63:32] : 32'd0;
  assign bus.lo_wdata    = bus.hilo_we ? res[31:0] : 32'd0;
  assign bus.div_by_zero = bus.hilo_we && dbz;
  assign bus.busy        = state != IDLE;
  assign bus.stallreq    = resetn && (accept || state == RUN);
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized scoreboard bench for mdu_ctrl against an arithmetic reference model
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          at;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sbq[$];
  exp_t mon_e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mdu_ctrl_if bus();
  mdu_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic exp_t model(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, input int at);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    e.at = at;
    p = 64'd0;
    if ((op == MDU_DIV || op == MDU_DIVU) && b == 32'd0) begin
      e.dbz = 1'b1;
      p = {a, 32'hFFFF_FFFF};
    end else if (op == MDU_MULT) begin
      p = sa * sb;
    end else if (op == MDU_MULTU) begin
      p = {32'd0, a} * {32'd0, b};
    end else if (op == MDU_DIV) begin
      q = sa / sb;
      r = sa % sb;
      p = {r[31:0], q[31:0]};
    end else begin
      p = {a % b, a / b};
    end
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction
  // monitor: every write strobe must match the oldest expected result; outputs idle at zero otherwise
  always @(negedge clk) begin
    if (bus.hilo_we) begin
      if (sbq.size() == 0) check("unexpected_hilo_we", 64'd1, 64'd0);
      else begin
        mon_e = sbq.pop_front();
        check("hi", {32'd0, bus.hi_wdata}, {32'd0, mon_e.hi});
        check("lo", {32'd0, bus.lo_wdata}, {32'd0, mon_e.lo});
        check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, mon_e.dbz});
        check("we_cycle", 64'(cyc), 64'(mon_e.at));
      end
    end else
      check("idle_zero", {bus.hi_wdata | bus.lo_wdata, 31'd0, bus.div_by_zero}, 64'd0);
  end
  task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    int n, lat;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op = op;
    bus.src_a = a;
    bus.src_b = b;
    n = cyc;
    lat = (op[1] && b == 32'd0) ? 1 : 33;
    sbq.push_back(model(op, a, b, n + lat));
    @(negedge clk);
    check("stall_accept", {63'd0, bus.stallreq}, 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    bus.op = mdu_op_e'($urandom_range(0, 3));
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("stall_run", {63'd0, bus.stallreq}, {63'd0, k < lat});
      check("busy_run", {63'd0, bus.busy}, 64'd1);
      bus.start = (k < lat - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(posedge clk); #1;
    check("drained", 64'(sbq.size()), 64'd0);
    check("busy_after", {63'd0, bus.busy}, 64'd0);
    sbq.delete();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a, b;
    mdu_op_e     op;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op = MDU_MULT;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    bus.start = 1'b1;
    #1;
    check("reset_ctl", {60'd0, bus.stallreq, bus.busy, bus.hilo_we, bus.div_by_zero}, 64'd0);
    check("reset_data", {bus.hi_wdata, bus.lo_wdata}, 64'd0);
    bus.start = 1'b0;
    @(negedge clk) resetn = 1'b1;
    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op(MDU_DIVU, 32'd100, 32'd7);
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(MDU_DIVU, 32'd5, 32'd0);
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(MDU_DIV, 32'h8000_0001, 32'd0);
    run_op(MDU_MULT, 32'h8000_0000, 32'h8000_0000);
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
    for (int i = 0; i < 40; i++) begin
      op = mdu_op_e'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : 32'($urandom);
      run_op(op, a, b);
    end
    // flush in the 10th RUN cycle: no write, idle next cycle, then a clean op
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op = MDU_MULTU;
    bus.src_a = 32'd123;
    bus.src_b = 32'd456;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(negedge clk);
    check("cancel_run_busy", {63'd0, bus.busy}, 64'd1);
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel_run_idle", {63'd0, bus.busy}, 64'd0);
    repeat (40) @(posedge clk);
    run_op(MDU_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    // flush in DONE suppresses the write strobe
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op = MDU_DIVU;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(negedge clk);
    check("cancel_done_we", {63'd0, bus.hilo_we}, 64'd0);
    check("cancel_done_busy", {63'd0, bus.busy}, 64'd1);
    check("cancel_done_stall", {63'd0, bus.stallreq}, 64'd0);
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel_done_idle", {63'd0, bus.busy}, 64'd0);
    // cancel beats a simultaneous start
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    bus.op = MDU_MULT;
    #1;
    check("cancel_start_stall", {63'd0, bus.stallreq}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    check("cancel_start_busy", {63'd0, bus.busy}, 64'd0);
    // asynchronous reset in the middle of RUN
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op = MDU_DIV;
    bus.src_a = 32'h8765_4321;
    bus.src_b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    bus.start = 1'b1;
    #1;
    check("midrun_reset_ctl", {60'd0, bus.stallreq, bus.busy, bus.hilo_we, bus.div_by_zero}, 64'd0);
    check("midrun_reset_data", {bus.hi_wdata, bus.lo_wdata}, 64'd0);
    bus.start = 1'b0;
    @(negedge clk) resetn = 1'b1;
    run_op(MDU_MULT, 32'hFFFF_FFF0, 32'd77);
    run_op(MDU_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFF3);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port start, input, 1 bit: EX-stage request to begin a multiply or divide.
REQ-004 The module SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The module SHALL have port src_a, input, 32 bits: multiplicand or dividend.
REQ-006 The module SHALL have port src_b, input, 32 bits: multiplier or divisor.
REQ-007 The module SHALL have port cancel, input, 1 bit: pipeline flush; abort any operation.
REQ-008 The module SHALL have port stallreq, output, 1 bit: request to hold the EX stage and all stages before it.
REQ-009 The module SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-010 The module SHALL have port hilo_we, output, 1 bit: one-cycle write strobe for HI/LO.
REQ-011 The module SHALL have ports hi_wdata and lo_wdata, output, 32 bits each: result values, valid while hilo_we is high.
REQ-012 The module SHALL have port div_by_zero, output, 1 bit: one-cycle flag, coincident with hilo_we.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE with start=1 and cancel=0: latch op; latch |src_a| and |src_b| (absolute value only for signed ops); record the sign bits; clear the 5-bit counter; go to RUN.
REQ-015 Exception to REQ-014: when IDLE, start=1, op is DIV/DIVU and src_b=0, the FSM SHALL go directly to DONE.
REQ-016 RUN SHALL execute one iteration per cycle, 32 iterations in total (counter 0..31), then go to DONE:
- multiply: shift-add, 64-bit accumulator;
- divide: restoring, 32-bit remainder and quotient.
REQ-017 DONE SHALL last exactly one cycle and assert hilo_we, then return to IDLE.
REQ-018 Latency: start sampled at cycle N gives hilo_we at cycle N+33; for divide-by-zero, hilo_we is at cycle N+1.
REQ-019 Multiply result: {hi_wdata, lo_wdata} is the 64-bit product; for MULT it is negated when sign_a XOR sign_b.
REQ-020 Divide result: lo_wdata is the quotient, negated when sign_a XOR sign_b (DIV only); hi_wdata is the remainder, negated when sign_a (DIV only).
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (32-bit wrap).
REQ-022 Divide by zero SHALL yield lo=0xFFFFFFFF, hi=src_a, div_by_zero=1.
REQ-023 stallreq SHALL equal (IDLE AND start AND NOT cancel) OR RUN, combinationally; it SHALL be low in DONE so the pipeline advances in the write cycle.
REQ-024 cancel=1 in RUN or DONE: go to IDLE next cycle; hilo_we stays 0 in that cycle.
REQ-025 cancel SHALL take priority over a simultaneous start.
REQ-026 start while in RUN or DONE SHALL be ignored.
REQ-027 hi_wdata and lo_wdata SHALL be 0 whenever hilo_we=0.

Reset
REQ-028 resetn=0 SHALL immediately force IDLE, with the counter and all latched operands cleared.
REQ-029 During reset, stallreq, busy, hilo_we, div_by_zero, hi_wdata and lo_wdata SHALL all be 0, including when reset arrives mid-RUN.
REQ-030 The first start SHALL be accepted on the first rising edge after resetn is released.

Structure
REQ-031 The shared defines header SHALL hold: op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), state encodings, and MDU_ITER=32.
REQ-032 The combinational per-iteration step (shift-add or restoring subtract) SHALL live in one sub-module, mdu_step; the FSM, counter and sign fix-up SHALL live in mdu_ctrl.

Verification
REQ-033 MULT 0xFFFFFFFF x 0x00000002, start at N -> stallreq high N..N+32; hilo_we at N+33 with hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-034 DIVU 100 / 7 -> lo=0x0000000E, hi=0x00000002 at N+33; div_by_zero=0.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIVU 5 / 0 -> hilo_we at N+1 with lo=0xFFFFFFFF, hi=5, div_by_zero=1; stallreq high only in cycle N.
REQ-037 MULTU start, cancel at the 10th RUN cycle -> no hilo_we, busy=0 next cycle; a new start then completes 33 cycles later.
REQ-038 resetn pulled low mid-RUN -> all outputs 0 with no clock edge; after release, IDLE and a clean restart.
